irq_controller: RTL and testbench
=================================

// Module: irq_controller
// PURPOSE
//  Prioritised interrupt controller that sequences the CPU's ISR entry/exit.
//  Latches rising edges on external IRQ lines and applies a software-written mask.
//  Holds the cpu isr request until the CPU acknowledges vectoring, then waits for
//  an end-of-interrupt (EOI) store. Sits beside the RAM on the CPU memory bus as a
//  memory-mapped peripheral.
// PARAMETERS
//  N_SRC      4       number of IRQ sources, 1..8; index 0 = highest priority
//  MASK_ADDR  9'h140  word address of the mask register (read/write)
//  STAT_ADDR  9'h141  word address of the status register (read-only)
//  EOI_ADDR   9'h142  word address of the EOI register (write-only; data ignored)
// PORTS
//  clk        in   1      rising-edge clock shared with cpu
//  reset      in   1      asynchronous, active-high reset
//  irq_in     in   N_SRC  source lines, synchronous to clk; a rising edge requests service
//  mem_cmd    in   2      cpu bus command: 2'b00 none, 2'b01 read, 2'b10 write
//  mem_addr   in   9      cpu bus word address
//  write_data in   16     cpu store data
//  irq_rdata  out  16     register read data; 0 when not hit
//  rd_hit     out  1      1 when mem_cmd==read and mem_addr is MASK_ADDR or STAT_ADDR
//  isr        out  1      drives cpu isr input; 1 while a request awaits acknowledge
//  isr_ack    in   1      one-cycle pulse from the cpu controller when it loads the ISR PC
//  src_id     out  3      source currently being requested or serviced
//  busy       out  1      1 in REQ or SERVICE
// BEHAVIOUR
//  Reset: state=IDLE; pending=0; mask=0 (all disabled); src_id=0; isr=0; busy=0;
//    irq_prev = all ones, so a line held high through reset gives no edge.
//    Reset asserted mid-operation drops isr and busy immediately; the request is lost.
//  Edge detect: edge[i] = irq_in[i] & ~irq_prev[i]; irq_prev <= irq_in every cycle.
//  pending[i] is set by edge[i] and cleared only on entry to SERVICE for src_id.
//    If set and clear hit the same bit in one cycle, set wins (bit stays 1).
//  eligible = pending & mask. Selection is fixed priority, lowest index first.
//  FSM (state held in registers; outputs decoded from state):
//   IDLE:    eligible!=0 -> REQ; src_id <= lowest set bit of eligible.
//   REQ:     isr=1. On isr_ack -> SERVICE and clear pending[src_id].
//            A mask change in REQ does not withdraw the latched request.
//   SERVICE: isr=0. Write to EOI_ADDR -> IDLE. Edges keep setting pending.
//            No nesting; a new eligible source is taken only after returning to IDLE.
//  Latency: edge at cycle t -> pending=1 at t+1 -> REQ/isr=1 at t+2 (if masked in).
//    After EOI, a remaining eligible source re-raises isr 2 cycles later.
//  Bus: writes occur on a clk edge when mem_cmd==2'b10.
//    MASK write: mask <= write_data[N_SRC-1:0].
//    Writes to STAT_ADDR are ignored.
//    EOI writes in IDLE or REQ are ignored.
//  Reads are combinational:
//    MASK_ADDR -> mask, zero-extended.
//    STAT_ADDR -> {3'b0, src_id[2:0], busy, isr, pending zero-extended to 8}.
//  Simultaneous isr_ack and EOI write: isr_ack is honoured first and EOI is ignored,
//    because the EOI is not in SERVICE.
//  isr_ack in IDLE or SERVICE is ignored.
// TESTING
//  1 Reset with irq_in=4'b0001 held high, mask=F -> no pending, isr stays 0.
//  2 mask=4'hF, edge on irq_in[2] at t -> isr=1 at t+2, src_id=2;
//    isr_ack -> SERVICE, pending=0; EOI -> IDLE.
//  3 Edges on sources 3 and 1 in the same cycle -> src_id=1 is serviced first;
//    after EOI, isr re-raises with src_id=3.
//  4 mask=4'b1011, edge on src 2 -> no isr and STAT pending=0x04;
//    write mask=F -> isr rises 1 cycle later with src_id=2.
//  5 In SERVICE (src 0), a new edge on src 0 sets pending[0];
//    after EOI, src 0 is requested again. EOI while in REQ is ignored.
//  6 Assert reset while in REQ -> isr=0 asynchronously; after release,
//    state=IDLE and mask=0.

Source files
------------

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : irq_controller
// Description : Prioritised, memory-mapped interrupt controller. Latches
//               rising edges on IRQ lines, masks them, raises the CPU isr
//               request for the highest-priority eligible source, and holds
//               off further requests until an end-of-interrupt store.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_controller #(
  parameter int          N_SRC     = 4,
  parameter logic [8:0]  MASK_ADDR = 9'h140,
  parameter logic [8:0]  STAT_ADDR = 9'h141,
  parameter logic [8:0]  EOI_ADDR  = 9'h142
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  irq_in,
  input  logic [1:0]        mem_cmd,
  input  logic [8:0]        mem_addr,
  input  logic [15:0]       write_data,
  output logic [15:0]       irq_rdata,
  output logic              rd_hit,
  output logic              isr,
  input  logic              isr_ack,
  output logic [2:0]        src_id,
  output logic              busy
);

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         src_id_q, src_id_d;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   mask_q, mask_d;
  logic [N_SRC-1:0]   irq_prev_q;

  logic [N_SRC-1:0]   w_edge;
  logic [N_SRC-1:0]   w_eligible;
  logic [N_SRC-1:0]   w_clr;
  logic [2:0]         w_sel_id;
  logic               w_any_eligible;
  logic               w_wr_mask;
  logic               w_wr_eoi;
  logic               w_rd_mask;
  logic               w_rd_stat;
  logic               w_ack_taken;
  logic [7:0]         w_pend_ext;
  logic [15:0]        w_mask_ext;

  // Only the low N_SRC bits of store data are meaningful.
  logic unused_wdata;
  assign unused_wdata = ^write_data;

  // Bus decode.
  assign w_wr_mask = (mem_cmd == CMD_WRITE) && (mem_addr == MASK_ADDR);
  assign w_wr_eoi  = (mem_cmd == CMD_WRITE) && (mem_addr == EOI_ADDR);
  assign w_rd_mask = (mem_cmd == CMD_READ)  && (mem_addr == MASK_ADDR);
  assign w_rd_stat = (mem_cmd == CMD_READ)  && (mem_addr == STAT_ADDR);

  assign w_edge         = irq_in & ~irq_prev_q;
  assign w_eligible     = pending_q & mask_q;
  assign w_any_eligible = |w_eligible;
  assign w_ack_taken    = (state_q == S_REQ) && isr_ack;

  // Fixed priority select: scan high to low so the lowest set index wins.
  always_comb begin
    w_sel_id = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_sel_id = i[2:0];
    end
  end

  // One-hot clear of the source being acknowledged into service.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_clr[i] = w_ack_taken && (src_id_q == i[2:0]);
    end
  end

  // Pending and mask next-state; a same-cycle edge overrides the clear.
  always_comb begin
    pending_d = (pending_q & ~w_clr) | w_edge;
    mask_d    = mask_q;
    if (w_wr_mask) mask_d = write_data[N_SRC-1:0];
  end

  // Request sequencing FSM: next-state and selected source.
  always_comb begin
    state_d  = state_q;
    src_id_d = src_id_q;
    case (state_q)
      S_IDLE: begin
        if (w_any_eligible) begin
          state_d  = S_REQ;
          src_id_d = w_sel_id;
        end
      end
      S_REQ: begin
        // A mask change here does not withdraw the latched request.
        if (isr_ack) state_d = S_SERVICE;
      end
      S_SERVICE: begin
        if (w_wr_eoi) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, registers and edge history; a line high through reset gives no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      src_id_q   <= 3'd0;
      pending_q  <= '0;
      mask_q     <= '0;
      irq_prev_q <= '1;
    end else begin
      state_q    <= state_d;
      src_id_q   <= src_id_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      irq_prev_q <= irq_in;
    end
  end

  // Outputs decoded from state so reset drops them immediately.
  assign isr    = (state_q == S_REQ);
  assign busy   = (state_q == S_REQ) || (state_q == S_SERVICE);
  assign src_id = src_id_q;

  // Zero-extend the per-source vectors to their register field widths.
  always_comb begin
    w_pend_ext                = '0;
    w_pend_ext[N_SRC-1:0]     = pending_q;
    w_mask_ext                = '0;
    w_mask_ext[N_SRC-1:0]     = mask_q;
  end

  // Combinational register read mux.
  always_comb begin
    irq_rdata = 16'h0000;
    if (w_rd_mask) irq_rdata = w_mask_ext;
    else if (w_rd_stat) irq_rdata = {3'b000, src_id_q, busy, isr, w_pend_ext};
  end

  assign rd_hit = w_rd_mask || w_rd_stat;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_controller
// Description : Directed self-checking bench for irq_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_in;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] irq_rdata;
  logic        rd_hit;
  logic        isr;
  logic        isr_ack;
  logic [2:0]  src_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  irq_controller dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .irq_rdata  (irq_rdata),
    .rd_hit     (rd_hit),
    .isr        (isr),
    .isr_ack    (isr_ack),
    .src_id     (src_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Combinational register read between clock edges.
  task automatic rd(input string tag, input logic [8:0] addr, input logic [15:0] exp);
    mem_cmd  = 2'b01;
    mem_addr = addr;
    #1;
    chk(tag, irq_rdata, exp);
    chk({tag, "_hit"}, {15'd0, rd_hit}, 16'd1);
    mem_cmd  = 2'b00;
    mem_addr = 9'h000;
  endtask

  // Single-cycle bus store.
  task automatic wr(input logic [8:0] addr, input logic [15:0] data);
    mem_cmd    = 2'b10;
    mem_addr   = addr;
    write_data = data;
    tick();
    mem_cmd    = 2'b00;
    mem_addr   = 9'h000;
    write_data = 16'h0000;
  endtask

  task automatic ack();
    isr_ack = 1'b1;
    tick();
    isr_ack = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; irq_in = 4'b0001; mem_cmd = 2'b00; mem_addr = 9'h000;
    write_data = 16'h0000; isr_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // 1: reset values, line 0 held high through reset gives no edge
    chk("rst_isr",  {15'd0, isr},  16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_src",  {13'd0, src_id}, 16'd0);
    rd("rst_mask", 9'h140, 16'h0000);
    rd("rst_stat", 9'h141, 16'h0000);
    wr(9'h140, 16'h000F);
    rd("mask_f", 9'h140, 16'h000F);
    tick(); tick();
    chk("held_isr", {15'd0, isr}, 16'd0);
    rd("held_stat", 9'h141, 16'h0000);
    irq_in = 4'b0000;
    tick();

    // 2: single source 2, latency t+1 pending, t+2 isr
    irq_in = 4'b0100;
    tick();
    irq_in = 4'b0000;
    chk("t1_isr", {15'd0, isr}, 16'd0);
    rd("t1_stat", 9'h141, 16'h0004);
    tick();
    chk("t2_isr", {15'd0, isr}, 16'd1);
    chk("t2_src", {13'd0, src_id}, 16'd2);
    rd("t2_stat", 9'h141, 16'h0B04);
    ack();
    chk("svc_isr", {15'd0, isr}, 16'd0);
    rd("svc_stat", 9'h141, 16'h0A00);
    wr(9'h142, 16'h1234);
    chk("eoi_busy", {15'd0, busy}, 16'd0);

    // 3: sources 3 and 1 together; 1 first, then 3
    irq_in = 4'b1010;
    tick();
    irq_in = 4'b0000;
    tick();
    chk("p3_isr", {15'd0, isr}, 16'd1);
    chk("p3_src", {13'd0, src_id}, 16'd1);
    ack();
    rd("p3_stat", 9'h141, 16'h0608);
    wr(9'h142, 16'h0000);
    chk("p3_idle_isr", {15'd0, isr}, 16'd0);
    tick();
    chk("p3_re_isr", {15'd0, isr}, 16'd1);
    chk("p3_re_src", {13'd0, src_id}, 16'd3);
    ack();
    wr(9'h142, 16'h0000);
    chk("p3_done", {15'd0, busy}, 16'd0);

    // 4: masked source 2 stays pending until unmasked
    wr(9'h140, 16'h000B);
    irq_in = 4'b0100;
    tick();
    irq_in = 4'b0000;
    tick();
    chk("m4_isr", {15'd0, isr}, 16'd0);
    rd("m4_stat", 9'h141, 16'h0C04);
    wr(9'h140, 16'h000F);
    chk("m4_isr0", {15'd0, isr}, 16'd0);
    tick();
    chk("m4_isr1", {15'd0, isr}, 16'd1);
    chk("m4_src", {13'd0, src_id}, 16'd2);
    ack();
    wr(9'h142, 16'h0000);

    // 5: re-edge during service, EOI ignored in REQ
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    tick();
    chk("s5_isr", {15'd0, isr}, 16'd1);
    wr(9'h142, 16'h0000);
    chk("s5_eoi_req", {15'd0, isr}, 16'd1);
    ack();
    rd("s5_svc", 9'h141, 16'h0200);
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    rd("s5_repend", 9'h141, 16'h0201);
    wr(9'h142, 16'h0000);
    chk("s5_idle", {15'd0, isr}, 16'd0);
    tick();
    chk("s5_again", {15'd0, isr}, 16'd1);
    chk("s5_src", {13'd0, src_id}, 16'd0);
    // simultaneous ack and EOI: ack taken, EOI ignored
    isr_ack = 1'b1;
    wr(9'h142, 16'h0000);
    isr_ack = 1'b0;
    chk("s5_sim_busy", {15'd0, busy}, 16'd1);
    chk("s5_sim_isr",  {15'd0, isr},  16'd0);
    wr(9'h142, 16'h0000);
    chk("s5_end", {15'd0, busy}, 16'd0);

    // 6: asynchronous reset in REQ
    irq_in = 4'b0010;
    tick();
    irq_in = 4'b0000;
    tick();
    chk("r6_req", {15'd0, isr}, 16'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("r6_async_isr",  {15'd0, isr},  16'd0);
    chk("r6_async_busy", {15'd0, busy}, 16'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("r6_busy", {15'd0, busy}, 16'd0);
    rd("r6_mask", 9'h140, 16'h0000);
    rd("r6_stat", 9'h141, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
